pc_replay_unit: RTL
===================

# pc_replay_unit

Parametrised PC-history and hazard-resolution unit for the in-order MIPS pipeline. It generates the fetch PC and keeps one PC, valid bit and destination-register tag per stage. It resolves register RAW hazards by replaying or stalling, restarts on stores that hit in-flight instruction addresses, and applies branch redirects. It sits between fetch and the control/datapath and gates every stage's side effects through its valid bits.

## Interface
- `XLEN`, 32: PC and address width.
- `DEPTH`, 4: number of tracked stages. Stage 0 is fetch, stage 1 is decode, stage `DEPTH-1` is writeback. Legal range ≥3.
- `STORE_STAGE`, 2: stage whose bus write is checked against in-flight PCs. Range 1..`DEPTH-1`.
- `BR_STAGE`, 2: stage that raises redirects. Range 1..`DEPTH-1`.
- `STALL_MODE`, 0: 0 = resolve RAW by replay, 1 = resolve RAW by stall.
- `RESET_PC`, 0: fetch address after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dec_rs_i`, `dec_rt_i`  in  5 each  source registers of the stage-1 instruction.
- `dec_rs_use_i`, `dec_rt_use_i`  in  1 each  the stage-1 instruction reads that source.
- `dec_rd_i`  in  5  destination register of the stage-1 instruction.
- `dec_we_i`  in  1  the stage-1 instruction writes `dec_rd_i`.
- `store_i`  in  1  the `STORE_STAGE` instruction writes the bus this cycle.
- `store_addr_i`  in  XLEN  byte address of that write.
- `redirect_i`  in  1  the `BR_STAGE` instruction redirects fetch.
- `redirect_pc_i`  in  XLEN  redirect target.
- `pc_o`  out  XLEN  fetch address (equals stage-0 PC).
- `stage_pc_o`  out  DEPTH*XLEN  per-stage PC, stage k at bits [k*XLEN +: XLEN].
- `stage_valid_o`  out  DEPTH  per-stage valid bits.
- `stall_o`  out  1  stages 0 and 1 hold this cycle.
- `event_o`  out  2  registered cause of the last pipeline change: 0 none, 1 RAW, 2 store, 3 redirect.

## Operation
- Reset: all stage PCs = `RESET_PC`, all valid = 0, all tags = 0, `event_o` = 0, `stall_o` = 0.
- Normal advance:
  - Stage k takes stage k-1's PC, valid and tag.
  - Stage 0 PC becomes PC+4 and stage 0 valid becomes 1.
  - Stage 1's tag is captured from `dec_rd_i`/`dec_we_i`.
- RAW hazard: the stage-1 instruction is valid and a used source equals the tag of a valid stage k in 2..`DEPTH-1` with write enable set and rd≠0.
  - `STALL_MODE`=0: next stage-0 PC = stage-1 PC. Stage 1 becomes invalid (bubble). Stages ≥2 advance.
  - `STALL_MODE`=1: stages 0 and 1 hold. A bubble enters stage 2. `stall_o`=1, combinational.
- Store hazard: `store_i` is set, the `STORE_STAGE` instruction is valid, and `store_addr_i[XLEN-1:2]` equals `PC[XLEN-1:2]` of a valid stage k<`STORE_STAGE`.
  - Restart from the oldest matching k: next stage-0 PC = that PC.
  - Stages 1..`STORE_STAGE` become invalid; older stages advance.
  - The store itself completes.
- Redirect: `redirect_i` is set and the `BR_STAGE` instruction is valid.
  - Next stage-0 PC = `redirect_pc_i`.
  - Stages 1..`BR_STAGE` become invalid; older stages advance.
- Priority when events coincide: redirect > store > RAW > normal.
- Inputs qualified by an invalid stage are ignored. Stores whose address does not match any in-flight PC have no effect.
- PC arithmetic is modulo 2^XLEN; 0xFFFFFFFC+4 wraps to 0.

## Timing
- Hazard detection is combinational on current state. Its effect appears in `pc_o` and the valid bits after the next edge.
- Replay penalty: 1 cycle per retry. RAW replay repeats until the writer reaches `DEPTH-1` and leaves.
- `event_o` is registered and reflects the previous cycle's decision.
- `rst` asserted mid-replay or mid-stall discards all state on the next edge.

## Structure
- Shared package `pipe_pkg`:
  - `event_t` enum (NONE, RAW, STORE, REDIRECT).
  - Stage-index constants.
  - Register-tag struct {we, rd}.
- One sub-module, `raw_detect`: combinational. Inputs are the sources and the tag/valid vectors; outputs are the hit flag and the youngest hit stage.

## Test plan
- Reset, then 5 free cycles → `pc_o` = 0,4,8,12,16; `stage_valid_o` fills 0001→0011→0111→1111.
- Writer rd=8 in stage 2, stage-1 instruction reads $8, `STALL_MODE`=0 → `pc_o` returns to the stage-1 PC and `event_o`=1. Same case with rd=0 → no hazard.
- Same hazard with `STALL_MODE`=1 → `stall_o`=1 for 2 cycles (DEPTH=4), `pc_o` held, stage 2 invalid.
- Store at stage 2 to address 0x1006 while stages 0 and 1 hold 0x1008 and 0x1004 → next `pc_o`=0x1004, stages 1..2 invalid.
- Redirect to 0x400 coinciding with a RAW hazard → `pc_o`=0x400 and `event_o`=3.
- Assert `rst` during a stall → next cycle `pc_o`=`RESET_PC`, all valid bits 0, `stall_o`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the PC-history / hazard-resolution unit.
package pipe_pkg;

    // Cause of the most recent pipeline change, as reported on event_o.
    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_RAW      = 2'd1,
        EV_STORE    = 2'd2,
        EV_REDIRECT = 2'd3
    } event_t;

    // Fixed stage positions; the first stage whose writer can cause a RAW hit
    // is the one immediately behind decode.
    localparam int FETCH_STG     = 0;
    localparam int DEC_STG       = 1;
    localparam int RAW_FIRST_STG = 2;

    localparam int REG_W = 5;

    // Destination-register tag carried with each in-flight instruction.
    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] rd;
    } tag_t;

endpackage

// File: rtl/raw_detect.sv
// Combinational RAW detector: compares the decode-stage sources against the
// destination tags of the valid stages behind decode.
module raw_detect
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SW    = $clog2(DEPTH)
) (
    input  logic [REG_W-1:0]                 rs_i,
    input  logic [REG_W-1:0]                 rt_i,
    input  logic                             rs_use_i,
    input  logic                             rt_use_i,
    input  tag_t [DEPTH-1:RAW_FIRST_STG]     tag_i,
    input  logic [DEPTH-1:RAW_FIRST_STG]     vld_i,
    output logic                             hit_o,
    output logic [SW-1:0]                    hit_stage_o
);

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit_o       = 1'b0;
        hit_stage_o = '0;
        for (int k = DEPTH - 1; k >= RAW_FIRST_STG; k--) begin
            if (vld_i[k] && tag_i[k].we && (tag_i[k].rd != '0) &&
                ((rs_use_i && (rs_i == tag_i[k].rd)) ||
                 (rt_use_i && (rt_i == tag_i[k].rd)))) begin
                hit_o       = 1'b1;
                hit_stage_o = SW'(k);
            end
        end
    end

endmodule

// File: rtl/pc_replay_unit.sv
// Fetch-PC generator with per-stage PC/valid/tag history. Resolves RAW hazards
// (replay or stall), restarts on stores into in-flight code and applies
// branch redirects. Priority: redirect > store > RAW > normal advance.
module pc_replay_unit
    import pipe_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 4,
    parameter int              STORE_STAGE = 2,
    parameter int              BR_STAGE    = 2,
    parameter int              STALL_MODE  = 0,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            dec_rs_i,
    input  logic [4:0]            dec_rt_i,
    input  logic                  dec_rs_use_i,
    input  logic                  dec_rt_use_i,
    input  logic [4:0]            dec_rd_i,
    input  logic                  dec_we_i,
    input  logic                  store_i,
    input  logic [XLEN-1:0]       store_addr_i,
    input  logic                  redirect_i,
    input  logic [XLEN-1:0]       redirect_pc_i,
    output logic [XLEN-1:0]       pc_o,
    output logic [DEPTH*XLEN-1:0] stage_pc_o,
    output logic [DEPTH-1:0]      stage_valid_o,
    output logic                  stall_o,
    output logic [1:0]            event_o
);

    localparam int SW = $clog2(DEPTH);

    logic [DEPTH-1:0][XLEN-1:0]   r_pc;
    logic [DEPTH-1:0]             r_vld;
    tag_t [DEPTH-1:RAW_FIRST_STG] r_tag;
    event_t                       r_event;

    logic            w_raw_hit;
    logic [SW-1:0]   w_raw_stage;
    logic            w_raw;
    logic            w_st_hit;
    logic [XLEN-1:0] w_st_pc;
    logic            w_store;
    logic            w_redir;

    raw_detect #(
        .DEPTH (DEPTH),
        .SW    (SW)
    ) u_raw (
        .rs_i        (dec_rs_i),
        .rt_i        (dec_rt_i),
        .rs_use_i    (dec_rs_use_i),
        .rt_use_i    (dec_rt_use_i),
        .tag_i       (r_tag),
        .vld_i       (r_vld[DEPTH-1:RAW_FIRST_STG]),
        .hit_o       (w_raw_hit),
        .hit_stage_o (w_raw_stage)
    );

    // The reported stage must lie behind decode; a hit elsewhere is not a RAW.
    assign w_raw   = r_vld[DEC_STG] && w_raw_hit && (int'(w_raw_stage) >= RAW_FIRST_STG);
    assign w_redir = redirect_i && r_vld[BR_STAGE];

    // Word-granular match of the store against younger in-flight PCs; the
    // ascending scan keeps the oldest match as the restart point.
    always_comb begin
        w_st_hit = 1'b0;
        w_st_pc  = '0;
        for (int k = 0; k < STORE_STAGE; k++) begin
            if (r_vld[k] && ((store_addr_i >> 2) == (r_pc[k] >> 2))) begin
                w_st_hit = 1'b1;
                w_st_pc  = r_pc[k];
            end
        end
    end

    assign w_store = store_i && r_vld[STORE_STAGE] && w_st_hit;

    // Stall only when a RAW is the winning event.
    assign stall_o = (STALL_MODE != 0) && w_raw && !w_redir && !w_store;

    // Advance the history, then override with the winning event's flush/hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_pc[k] <= RESET_PC;
            r_vld   <= '0;
            r_tag   <= '0;
            r_event <= EV_NONE;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                r_pc[k]  <= r_pc[k-1];
                r_vld[k] <= r_vld[k-1];
            end
            r_tag[RAW_FIRST_STG] <= '{we: dec_we_i, rd: dec_rd_i};
            for (int k = RAW_FIRST_STG + 1; k < DEPTH; k++) r_tag[k] <= r_tag[k-1];
            r_pc[FETCH_STG]  <= r_pc[FETCH_STG] + XLEN'(4);
            r_vld[FETCH_STG] <= 1'b1;
            r_event          <= EV_NONE;

            if (w_redir) begin
                r_pc[FETCH_STG] <= redirect_pc_i;
                for (int k = 1; k <= BR_STAGE; k++) r_vld[k] <= 1'b0;
                r_event <= EV_REDIRECT;
            end else if (w_store) begin
                r_pc[FETCH_STG] <= w_st_pc;
                for (int k = 1; k <= STORE_STAGE; k++) r_vld[k] <= 1'b0;
                r_event <= EV_STORE;
            end else if (w_raw) begin
                r_event <= EV_RAW;
                if (STALL_MODE == 0) begin
                    // Refetch the reader; neither it nor its successor proceeds.
                    r_pc[FETCH_STG]      <= r_pc[DEC_STG];
                    r_vld[DEC_STG]       <= 1'b0;
                    r_vld[RAW_FIRST_STG] <= 1'b0;
                end else begin
                    r_pc[FETCH_STG]      <= r_pc[FETCH_STG];
                    r_vld[FETCH_STG]     <= r_vld[FETCH_STG];
                    r_pc[DEC_STG]        <= r_pc[DEC_STG];
                    r_vld[DEC_STG]       <= r_vld[DEC_STG];
                    r_vld[RAW_FIRST_STG] <= 1'b0;
                end
            end
        end
    end

    assign pc_o          = r_pc[FETCH_STG];
    assign stage_pc_o    = r_pc;
    assign stage_valid_o = r_vld;
    assign event_o       = r_event;

endmodule
